spi_register_controller: RTL and testbench
==========================================

# spi_register_controller

Sequences the SPI slave byte stream into the PWM expander's register file. Decodes a command byte, then auto-incrementing write/read data bytes, and stages writes in shadow registers. All shadows commit atomically to the live PWM duty/enable outputs when `_CS` deasserts. It also supplies `TXDataLine` to the slave for read-back. Runs on the system clock and synchronizes the slave's SCLK-domain status signals internally.

## Interface
- `NUM_CHANNELS`, default 8: PWM channels, range 1..8. Register map: addr 0..NUM_CHANNELS-1 are duty bytes; addr NUM_CHANNELS is the enable mask (low NUM_CHANNELS bits).
- `CLK` input, 1 bit: system clock. The single clock of the block.
- `_RST` input, 1 bit: reset. Synchronous, active-low.
- `_CS` input, 1 bit: SPI chip select, active-low, asynchronous to `CLK`.
- `TranscationCompleted` input, 1 bit: byte-done from the SPI slave. Asynchronous. High for at least 3 `CLK` periods per byte.
- `RXDataLine` input, 8 bits: received byte. Stable from the rise of `TranscationCompleted` until the next byte completes.
- `TXDataLine` output, 8 bits: byte the slave shifts out on the next transfer.
- `DutyCycles` output, 8*NUM_CHANNELS bits: live duty registers. Channel n occupies bits [8n+7:8n].
- `ChannelEnable` output, NUM_CHANNELS bits: live enable mask.
- `UpdateStrobe` output, 1 bit: one-cycle pulse when the live registers are committed.
- `Busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
**Input synchronization**
- `_CS` and `TranscationCompleted` each pass through a 2-flop synchronizer followed by an edge detector.
- Edge events:
  - CS_FALL: falling edge of synchronized `_CS`.
  - CS_RISE: rising edge of synchronized `_CS`.
  - BYTE: rising edge of synchronized `TranscationCompleted`.

**Frame format**
- Byte 0 is the command: bit7 = 1 means write, 0 means read; bits[6:0] are the start address.
- Each following byte targets the current address. The address then increments modulo 128.

**FSM states**
- IDLE: on CS_FALL, set `TXDataLine` = 0x00, set `frame_wr` = 0, go to CMD.
- CMD: on BYTE, load addr = `RXDataLine[6:0]`.
  - If bit7 = 1, go to WRITE.
  - If bit7 = 0, go to READ; set `TXDataLine` = reg[addr] and increment addr.
- WRITE: on BYTE, if addr ≤ NUM_CHANNELS, shadow[addr] = `RXDataLine` and `frame_wr` = 1. Then increment addr.
- READ: on BYTE, set `TXDataLine` = reg[addr] and increment addr.
- Any state other than IDLE: on CS_RISE, go to IDLE. CS_RISE takes priority over a BYTE in the same cycle; that BYTE is discarded.

**Register rules**
- Reads return the live registers, not the shadows.
- An out-of-range address reads as 0x00; writes to it are dropped, but addr still increments.
- The enable register reads zero-extended to 8 bits; writes to it keep the low NUM_CHANNELS bits.

**Commit**
- On CS_RISE with `frame_wr` = 1, copy every shadow to its live register in one cycle and pulse `UpdateStrobe`.
- A frame with no in-range write data byte produces no commit and no strobe.
- Shadows are reloaded from the live values at every CS_FALL. Registers not written in a frame therefore commit unchanged.
- CS_RISE in the middle of a byte discards the partial byte. Completed data bytes in that frame still commit.

## Timing
**Reset** (`_RST` low at a `CLK` edge):
- State goes to IDLE.
- `TXDataLine` = 0x00, `DutyCycles` = 0, `ChannelEnable` = 0, shadows = 0.
- `UpdateStrobe` = 0, `Busy` = 0.
- Synchronizer flops clear.
- An in-flight frame is abandoned and nothing commits. If `_CS` is already low when reset releases, no CS_FALL is seen until `_CS` has been observed high.

**Latency**
- Event detection: the edge event is registered 3 `CLK` edges after the input changes.
- Action: state, addr, shadow and `TXDataLine` update on the `CLK` edge after the event (event + 1).
- Commit: `DutyCycles` and `ChannelEnable` change on the same edge that `UpdateStrobe` rises. `UpdateStrobe` is high for exactly one cycle.
- `Busy` rises at CS_FALL + 1 and falls at CS_RISE + 1.
- System constraint: `CLK` ≥ 8× SCLK. `TXDataLine` is then valid at most 5 `CLK` after a byte completes, before the next byte's first SCLK edge.

## Test plan
- Reset: hold `_RST` low for 2 cycles → all outputs 0, `Busy` = 0.
- Write frame 0x82, 0x40, 0x80, 0xFF (addrs 2, 3, 4); NUM_CHANNELS = 8 → outputs unchanged until `_CS` rises. Then one `UpdateStrobe` pulse; ch2 = 0x40, ch3 = 0x80, ch4 = 0xFF; other channels 0.
- Read frame 0x02 after the previous test → `TXDataLine` = 0x40 after byte 0, 0x80 after byte 1, 0xFF after byte 2. No `UpdateStrobe`.
- Write 0x88, 0x5A, 0x11 (enable register, then addr 9 out of range) → `ChannelEnable` = 0x5A after commit. Addr 9 write dropped; a read of addr 9 returns 0x00.
- Abort: write 0x81, 0x33, then raise `_CS` after 4 SCLKs of the next byte → ch1 = 0x33 committed, partial byte ignored. Assert `_RST` during a later write frame → no commit, all outputs 0.
- Wrap and collision: write with command 0xFF followed by 2 data bytes → addr 127 dropped, addr 0 (wrapped) written. Drive CS_RISE and BYTE events in the same cycle → the byte is discarded.

Source files
------------

// File: rtl/spi_register_controller_if.sv
// Bus between the SPI slave front-end and the PWM register controller.
// The slave modport is the controller's view; the master modport is the SPI side.
interface spi_register_controller_if #(
  parameter int unsigned NUM_CHANNELS = 8
);
  logic                      _CS;
  logic                      TranscationCompleted;
  logic [7:0]                RXDataLine;
  logic [7:0]                TXDataLine;
  logic [8*NUM_CHANNELS-1:0] DutyCycles;
  logic [NUM_CHANNELS-1:0]   ChannelEnable;
  logic                      UpdateStrobe;
  logic                      Busy;

  modport master (
    output _CS,
    output TranscationCompleted,
    output RXDataLine,
    input  TXDataLine,
    input  DutyCycles,
    input  ChannelEnable,
    input  UpdateStrobe,
    input  Busy
  );

  modport slave (
    input  _CS,
    input  TranscationCompleted,
    input  RXDataLine,
    output TXDataLine,
    output DutyCycles,
    output ChannelEnable,
    output UpdateStrobe,
    output Busy
  );
endinterface

// File: rtl/spi_register_controller.sv
// Sequences SPI slave bytes into a shadowed PWM register file; shadows commit
// atomically to the live duty/enable outputs when chip select deasserts.
module spi_register_controller #(
  parameter int unsigned NUM_CHANNELS = 8
) (
  input logic                     CLK,
  input logic                     _RST,
  spi_register_controller_if.slave bus
);

  localparam logic [6:0] EnAddr = 7'(NUM_CHANNELS);

  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;

  // Synchronizers and registered edge events
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic tc_meta_q, tc_sync_q, tc_prev_q;
  logic cs_fall_q, cs_rise_q, byte_q;

  state_e                  state_q, state_d;
  logic [6:0]              addr_q, addr_d;
  logic                    frame_wr_q, frame_wr_d;
  logic [7:0]              tx_q, tx_d;
  logic [7:0]              shadow_q [NUM_CHANNELS];
  logic [7:0]              shadow_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] shadow_en_q, shadow_en_d;
  logic [7:0]              duty_q [NUM_CHANNELS];
  logic [7:0]              duty_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] en_q, en_d;
  logic                    strobe_q, strobe_d;

  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  // Flops clear to 0, so a _CS already low at reset release never yields a fall.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      cs_meta_q <= 1'b0;
      cs_sync_q <= 1'b0;
      cs_prev_q <= 1'b0;
      tc_meta_q <= 1'b0;
      tc_sync_q <= 1'b0;
      tc_prev_q <= 1'b0;
      cs_fall_q <= 1'b0;
      cs_rise_q <= 1'b0;
      byte_q    <= 1'b0;
    end else begin
      cs_meta_q <= bus._CS;
      cs_sync_q <= cs_meta_q;
      cs_prev_q <= cs_sync_q;
      tc_meta_q <= bus.TranscationCompleted;
      tc_sync_q <= tc_meta_q;
      tc_prev_q <= tc_sync_q;
      cs_fall_q <= cs_prev_q & ~cs_sync_q;
      cs_rise_q <= ~cs_prev_q & cs_sync_q;
      byte_q    <= ~tc_prev_q & tc_sync_q;
    end
  end

  // The command byte reads from the address it carries, not the stale addr_q.
  always_comb begin
    rd_addr = (state_q == StCmd) ? bus.RXDataLine[6:0] : addr_q;
    rd_data = 8'h00;
    if (rd_addr == EnAddr) begin
      rd_data = 8'(en_q);
    end
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_addr == 7'(i)) begin
        rd_data = duty_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    frame_wr_d  = frame_wr_q;
    tx_d        = tx_q;
    shadow_d    = shadow_q;
    shadow_en_d = shadow_en_q;
    duty_d      = duty_q;
    en_d        = en_q;
    strobe_d    = 1'b0;

    if (state_q == StIdle) begin
      if (cs_fall_q) begin
        state_d     = StCmd;
        tx_d        = 8'h00;
        frame_wr_d  = 1'b0;
        shadow_d    = duty_q;
        shadow_en_d = en_q;
      end
    end else if (cs_rise_q) begin
      // Chip-select release wins over a coincident byte, which is dropped.
      state_d = StIdle;
      if (frame_wr_q) begin
        duty_d   = shadow_q;
        en_d     = shadow_en_q;
        strobe_d = 1'b1;
      end
    end else if (byte_q) begin
      case (state_q)
        StCmd: begin
          addr_d = bus.RXDataLine[6:0];
          if (bus.RXDataLine[7]) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
            tx_d    = rd_data;
            addr_d  = bus.RXDataLine[6:0] + 7'd1;
          end
        end
        StWrite: begin
          for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (addr_q == 7'(i)) begin
              shadow_d[i] = bus.RXDataLine;
              frame_wr_d  = 1'b1;
            end
          end
          if (addr_q == EnAddr) begin
            shadow_en_d = bus.RXDataLine[NUM_CHANNELS-1:0];
            frame_wr_d  = 1'b1;
          end
          addr_d = addr_q + 7'd1;
        end
        StRead: begin
          tx_d   = rd_data;
          addr_d = addr_q + 7'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RST) begin
      state_q     <= StIdle;
      addr_q      <= 7'd0;
      frame_wr_q  <= 1'b0;
      tx_q        <= 8'h00;
      shadow_en_q <= '0;
      en_q        <= '0;
      strobe_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        shadow_q[i] <= 8'h00;
        duty_q[i]   <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      frame_wr_q  <= frame_wr_d;
      tx_q        <= tx_d;
      shadow_en_q <= shadow_en_d;
      en_q        <= en_d;
      strobe_q    <= strobe_d;
      shadow_q    <= shadow_d;
      duty_q      <= duty_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_duty_out
    assign bus.DutyCycles[8*g +: 8] = duty_q[g];
  end

  assign bus.TXDataLine    = tx_q;
  assign bus.ChannelEnable = en_q;
  assign bus.UpdateStrobe  = strobe_q;
  assign bus.Busy          = (state_q != StIdle);

  a_strobe_single : assert property (@(posedge CLK) disable iff (!_RST) strobe_q |=> !strobe_q);
  a_strobe_idle   : assert property (@(posedge CLK) disable iff (!_RST)
                                     strobe_q |-> state_q == StIdle);

endmodule

// File: tb/tb_spi_register_controller.sv
// Scoreboard bench for spi_register_controller: expected TX bytes and commits are
// queued as frames are driven and retired when the DUT produces them.
module tb_spi_register_controller;

  localparam int unsigned N = 8;

  logic CLK = 1'b0;
  logic _RST;

  spi_register_controller_if #(.NUM_CHANNELS(N)) bus ();

  spi_register_controller #(.NUM_CHANNELS(N)) dut (
    .CLK  (CLK),
    ._RST (_RST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  live_duty [N];
  logic [7:0]  live_en;
  logic [71:0] commit_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  fb[$];
  int          strobe_run = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_duty();
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = live_duty[i];
    return v;
  endfunction

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    if (a < N) return live_duty[a];
    if (a == N) return live_en;
    return 8'h00;
  endfunction

  // Commit monitor: every strobe must match a queued commit and last one cycle.
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge CLK);
      if (bus.UpdateStrobe === 1'b1) begin
        strobe_run++;
        if (strobe_run == 1) begin
          check("strobe_expected", 72'(commit_q.size() != 0), 72'd1);
          if (commit_q.size() != 0) begin
            e = commit_q.pop_front();
            check("commit_value", {bus.DutyCycles, bus.ChannelEnable}, e);
          end
        end
      end else begin
        if (strobe_run != 0) check("strobe_width", 72'(strobe_run), 72'd1);
        strobe_run = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input bit with_cs_rise);
    bus.RXDataLine = b;
    repeat (2) @(posedge CLK);
    #1;
    if (with_cs_rise) bus._CS = 1'b1;
    bus.TranscationCompleted = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    bus.TranscationCompleted = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // mode 0: normal end; 1: partial byte then CS rise; 2: last byte collides with CS rise
  task automatic do_frame(input logic [7:0] b[$], input int mode);
    logic [7:0] sh [N];
    logic [7:0] sh_en;
    logic [6:0] a;
    bit         wr;
    bit         fw;
    int         nfull;
    fw = 1'b0;
    a  = 7'd0;
    wr = 1'b0;
    check("busy_idle", 72'(bus.Busy), 72'd0);
    bus._CS = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("busy_frame", 72'(bus.Busy), 72'd1);
    sh    = live_duty;
    sh_en = live_en;
    nfull = (mode == 2) ? b.size() - 1 : b.size();
    for (int i = 0; i < nfull; i++) begin
      if (i == 0) begin
        a  = b[0][6:0];
        wr = b[0][7];
        if (wr) begin
          tx_q.push_back(8'h00);
        end else begin
          tx_q.push_back(model_rd(a));
          a++;
        end
      end else if (wr) begin
        if (a < N) begin
          sh[a] = b[i];
          fw    = 1'b1;
        end else if (a == N) begin
          sh_en = b[i];
          fw    = 1'b1;
        end
        a++;
        tx_q.push_back(8'h00);
      end else begin
        tx_q.push_back(model_rd(a));
        a++;
      end
      send_byte(b[i], 1'b0);
      check("tx_data", 72'(bus.TXDataLine), 72'(tx_q.pop_front()));
    end
    check("duty_hold", 72'(bus.DutyCycles), 72'(pack_duty()));
    check("en_hold", 72'(bus.ChannelEnable), 72'(live_en));
    if (fw) begin
      live_duty = sh;
      live_en   = sh_en;
      commit_q.push_back({pack_duty(), live_en});
    end
    if (mode == 1) begin
      bus.RXDataLine = 8'hC3;
      repeat (4) @(posedge CLK);
      #1;
      bus._CS = 1'b1;
    end else if (mode == 2) begin
      send_byte(b[nfull], 1'b1);
    end else begin
      bus._CS = 1'b1;
    end
    repeat (8) @(posedge CLK);
    #1;
    check("busy_end", 72'(bus.Busy), 72'd0);
    check("commit_drained", 72'(commit_q.size()), 72'd0);
    check("duty_live", 72'(bus.DutyCycles), 72'(pack_duty()));
    check("en_live", 72'(bus.ChannelEnable), 72'(live_en));
  endtask

  initial begin
    logic [7:0] ra;
    for (int i = 0; i < N; i++) live_duty[i] = 8'h00;
    live_en                  = 8'h00;
    _RST                     = 1'b0;
    bus._CS                  = 1'b1;
    bus.TranscationCompleted = 1'b0;
    bus.RXDataLine           = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tx", 72'(bus.TXDataLine), 72'd0);
    check("rst_duty", 72'(bus.DutyCycles), 72'd0);
    check("rst_en", 72'(bus.ChannelEnable), 72'd0);
    check("rst_strobe", 72'(bus.UpdateStrobe), 72'd0);
    check("rst_busy", 72'(bus.Busy), 72'd0);
    _RST = 1'b1;
    repeat (6) @(posedge CLK);
    #1;

    fb = '{8'h82, 8'h40, 8'h80, 8'hFF};
    do_frame(fb, 0);
    fb = '{8'h02, 8'h00, 8'h00};
    do_frame(fb, 0);
    fb = '{8'h88, 8'h5A, 8'h11};
    do_frame(fb, 0);
    fb = '{8'h09, 8'h00};
    do_frame(fb, 0);
    fb = '{8'h08, 8'h00};
    do_frame(fb, 0);
    fb = '{8'h83};
    do_frame(fb, 0);
    fb = '{8'h90, 8'h12};
    do_frame(fb, 0);
    fb = '{8'h81, 8'h33};
    do_frame(fb, 1);
    fb = '{8'hFF, 8'hAA, 8'hBB};
    do_frame(fb, 0);
    fb = '{8'h81, 8'h77, 8'h99};
    do_frame(fb, 2);

    for (int k = 0; k < 3; k++) begin
      ra = 8'($urandom_range(0, N));
      fb = '{8'h80 | ra, 8'($urandom), 8'($urandom), 8'($urandom)};
      do_frame(fb, 0);
    end
    fb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(fb, 0);

    // Reset in the middle of a write frame: nothing may commit.
    bus._CS = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    send_byte(8'h81, 1'b0);
    send_byte(8'h66, 1'b0);
    _RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    _RST = 1'b1;
    for (int i = 0; i < N; i++) live_duty[i] = 8'h00;
    live_en = 8'h00;
    repeat (6) @(posedge CLK);
    #1;
    check("rst_mid_busy", 72'(bus.Busy), 72'd0);
    check("rst_mid_duty", 72'(bus.DutyCycles), 72'd0);
    check("rst_mid_en", 72'(bus.ChannelEnable), 72'd0);
    bus._CS = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    check("rst_mid_after_duty", 72'(bus.DutyCycles), 72'd0);
    check("rst_mid_after_busy", 72'(bus.Busy), 72'd0);
    fb = '{8'h01, 8'h00};
    do_frame(fb, 0);
    fb = '{8'h80, 8'h12};
    do_frame(fb, 0);

    repeat (4) @(posedge CLK);
    #1;
    check("commit_final", 72'(commit_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
